// File: rtl/fixed_point_pow.sv
// Multi-cycle signed fixed-point power unit: result = a ** floor(b), Qi.f operands.
// One multiply per cycle, then a restoring reciprocal division for negative exponents.
module fixed_point_pow #(
  parameter int INTEGER_PART_WIDTH    = 3,
  parameter int FRACTIONAL_PART_WIDTH = 2
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                start,
  output logic                                                done,
  input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] a,
  input  logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] b,
  output logic [INTEGER_PART_WIDTH+FRACTIONAL_PART_WIDTH-1:0] result
);

  localparam int I   = INTEGER_PART_WIDTH;
  localparam int F   = FRACTIONAL_PART_WIDTH;
  localparam int N   = I + F;
  localparam int PW  = 2 * N;
  localparam int QW  = 2 * F + 1;
  localparam int XW  = QW + N;
  localparam int DCW = $clog2(QW + 1);

  localparam logic [N-1:0]  ONE      = N'(1) << F;
  localparam logic [N-1:0]  CAP      = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  MAX_POS  = {1'b0, {(N-1){1'b1}}};
  localparam logic [QW-1:0] DVD_INIT = {1'b1, {(QW-1){1'b0}}};

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] MUL    = 2'd1;
  localparam logic [1:0] DIV    = 2'd2;
  localparam logic [1:0] FINISH = 2'd3;

  logic [1:0]     state_r;
  logic           done_r;
  logic [N-1:0]   result_r;
  logic [N-1:0]   mag_r;
  logic [N-1:0]   abs_a_r;
  logic [I-1:0]   cnt_r;
  logic           neg_r;
  logic           recip_r;
  logic [N:0]     rem_r;
  logic [QW-1:0]  dvd_r;
  logic [QW-1:0]  q_r;
  logic [DCW-1:0] dcnt_r;

  logic signed [I-1:0] n_s;
  logic [I-1:0]        n_abs_s;
  logic [N-1:0]        abs_a_s;
  logic [PW-1:0]       shifted_s;
  logic [N-1:0]        mul_next_s;
  logic [N+1:0]        trial_s;
  logic                ge_s;
  logic [N:0]          rem_next_s;
  logic [QW-1:0]       q_next_s;
  logic [N-1:0]        div_mag_s;
  logic [N-1:0]        fin_result_s;

  // Clamp an unsigned wide value to the saturation cap.
  function automatic logic [N-1:0] clamp_cap(input logic [XW+PW-1:0] v);
    if (v >= (XW+PW)'(CAP)) begin
      return CAP;
    end else begin
      return N'(v);
    end
  endfunction

  // Operand decode, multiply step, division step and final signed result.
  always_comb begin
    n_s          = I'($signed(b) >>> F);
    n_abs_s      = n_s[I-1] ? (~n_s + I'(1)) : n_s;
    abs_a_s      = a[N-1] ? (~a + N'(1)) : a;
    shifted_s    = (PW'(mag_r) * PW'(abs_a_r)) >> F;
    mul_next_s   = CAP;
    if (mag_r != CAP) begin
      mul_next_s = clamp_cap((XW+PW)'(shifted_s));
    end else begin
      mul_next_s = CAP;
    end
    trial_s      = {rem_r, dvd_r[QW-1]};
    ge_s         = (trial_s >= (N+2)'(mag_r));
    if (ge_s) begin
      rem_next_s = (N+1)'(trial_s - (N+2)'(mag_r));
    end else begin
      rem_next_s = (N+1)'(trial_s);
    end
    q_next_s     = {q_r[QW-2:0], ge_s};
    if (mag_r == '0) begin
      div_mag_s  = CAP;
    end else begin
      div_mag_s  = clamp_cap((XW+PW)'(q_next_s));
    end
    if (neg_r) begin
      fin_result_s = ~mag_r + N'(1);
    end else if (mag_r == CAP) begin
      fin_result_s = MAX_POS;
    end else begin
      fin_result_s = mag_r;
    end
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      done_r   <= 1'b1;
      result_r <= '0;
      mag_r    <= '0;
      abs_a_r  <= '0;
      cnt_r    <= '0;
      neg_r    <= 1'b0;
      recip_r  <= 1'b0;
      rem_r    <= '0;
      dvd_r    <= '0;
      q_r      <= '0;
      dcnt_r   <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mag_r   <= ONE;
            abs_a_r <= abs_a_s;
            neg_r   <= a[N-1] & n_s[0];
            cnt_r   <= n_abs_s;
            recip_r <= n_s[I-1];
            done_r  <= 1'b0;
            state_r <= MUL;
          end else begin
            state_r <= IDLE;
          end
        end
        MUL: begin
          if (cnt_r != '0) begin
            mag_r <= mul_next_s;
            cnt_r <= cnt_r - I'(1);
          end else if (recip_r) begin
            rem_r   <= '0;
            dvd_r   <= DVD_INIT;
            q_r     <= '0;
            dcnt_r  <= '0;
            state_r <= DIV;
          end else begin
            state_r <= FINISH;
          end
        end
        DIV: begin
          rem_r <= rem_next_s;
          dvd_r <= dvd_r << 1;
          q_r   <= q_next_s;
          // The last quotient bit lands this cycle, so take the combinational quotient.
          if (dcnt_r == DCW'(QW - 1)) begin
            mag_r   <= div_mag_s;
            state_r <= FINISH;
          end else begin
            dcnt_r <= dcnt_r + DCW'(1);
          end
        end
        FINISH: begin
          result_r <= fin_result_s;
          done_r   <= 1'b1;
          state_r  <= IDLE;
        end
        default: begin
          done_r  <= 1'b1;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_fixed_point_pow.sv
// Bench for fixed_point_pow: a Q3.2 instance swept exhaustively and a Q4.2 instance
// driven with the hand-computed vectors; both checked every cycle against a behavioural model.
module tb_fixed_point_pow;

  localparam int F  = 2;
  localparam int IA = 3;
  localparam int NA = IA + F;
  localparam int IB = 4;
  localparam int NB = IB + F;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_a = 1'b0;
  logic [NA-1:0] a_a = '0;
  logic [NA-1:0] b_a = '0;
  logic [NA-1:0] res_a;
  logic          done_a;
  logic          start_b = 1'b0;
  logic [NB-1:0] a_b = '0;
  logic [NB-1:0] b_b = '0;
  logic [NB-1:0] res_b;
  logic          done_b;

  int checks   = 0;
  int failures = 0;
  bit exp_done [2];
  int exp_res  [2];

  always #5 clk = ~clk;

  fixed_point_pow #(.INTEGER_PART_WIDTH(IA), .FRACTIONAL_PART_WIDTH(F)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .done(done_a), .a(a_a), .b(b_a), .result(res_a)
  );

  fixed_point_pow #(.INTEGER_PART_WIDTH(IB), .FRACTIONAL_PART_WIDTH(F)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .done(done_b), .a(a_b), .b(b_b), .result(res_b)
  );

  function automatic int sext(input int v, input int w);
    int m;
    m = v & ((1 << w) - 1);
    if (m >= (1 << (w - 1))) m = m - (1 << w);
    return m;
  endfunction

  function automatic int floor_exp(input int bv, input int w);
    return sext(bv, w) >>> F;
  endfunction

  // a ** floor(b) from the arithmetic rules, on plain integers
  function automatic int model(input int av_raw, input int bv_raw, input int iw);
    int w, av, n, mag, cap, absa, q;
    w    = iw + F;
    av   = sext(av_raw, w);
    n    = floor_exp(bv_raw, w);
    cap  = 1 << (w - 1);
    absa = (av < 0) ? -av : av;
    mag  = 1 << F;
    for (int k = 0; k < ((n < 0) ? -n : n); k++) begin
      if (mag != cap) begin
        mag = (mag * absa) / (1 << F);
        if (mag > cap) mag = cap;
      end
    end
    if (n < 0) begin
      if (mag == 0) begin
        mag = cap;
      end else begin
        q   = (1 << (2 * F)) / mag;
        mag = (q > cap) ? cap : q;
      end
    end
    if (av < 0 && (n % 2) != 0) return -mag;
    return (mag > cap - 1) ? cap - 1 : mag;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic compare_outputs();
    check("done_q32", int'(done_a), int'(exp_done[0]));
    check("result_q32", sext(int'(res_a), NA), exp_res[0]);
    check("done_q42", int'(done_b), int'(exp_done[1]));
    check("result_q42", sext(int'(res_b), NB), exp_res[1]);
  endtask

  task automatic tick();
    @(negedge clk);
    compare_outputs();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input int av, input int bv, input logic st);
    if (sel == 0) begin
      start_a = st;
      a_a     = av[NA-1:0];
      b_a     = bv[NA-1:0];
    end else begin
      start_b = st;
      a_b     = av[NB-1:0];
      b_b     = bv[NB-1:0];
    end
  endtask

  // One operation with cycle-exact expectations; optional literal pins the model.
  task automatic run_op(input int sel, input int av, input int bv, input bit use_lit,
                        input int lit, input bit mid_pulse);
    int w, n, lat, want;
    w    = (sel == 0) ? NA : NB;
    want = model(av, bv, w - F);
    n    = floor_exp(bv, w);
    lat  = (n >= 0) ? n + 2 : -n + 2 * F + 3;
    if (use_lit) check("model_pin", want, lit);
    drive(sel, av, bv, 1'b1);
    tick();
    exp_done[sel] = 1'b0;
    drive(sel, int'($urandom), int'($urandom), 1'b0);
    for (int k = 1; k <= lat; k++) begin
      if (mid_pulse && k == 2) drive(sel, 12, 12, 1'b1);
      if (mid_pulse && k == 3) drive(sel, 12, 12, 1'b0);
      tick();
    end
    exp_done[sel] = 1'b1;
    exp_res[sel]  = want;
  endtask

  initial begin
    exp_done[0] = 1'b1;
    exp_done[1] = 1'b1;
    exp_res[0]  = 0;
    exp_res[1]  = 0;
    @(posedge clk);
    #1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Hand-computed Q4.2 vectors (raw values, scale 4)
    run_op(1, 8, 8, 1'b1, 16, 1'b0);
    run_op(1, -6, 12, 1'b1, -13, 1'b0);
    run_op(1, 12, 12, 1'b1, 31, 1'b0);
    run_op(1, -12, 12, 1'b1, -32, 1'b0);
    run_op(1, 12, -12, 1'b1, 0, 1'b0);
    run_op(1, 8, -4, 1'b1, 2, 1'b0);
    run_op(1, 8, -1, 1'b1, 2, 1'b0);
    run_op(1, 0, 0, 1'b1, 4, 1'b0);
    run_op(1, 0, -4, 1'b1, 31, 1'b0);
    run_op(1, -8, -4, 1'b1, -2, 1'b0);
    run_op(1, 8, 7, 1'b1, 8, 1'b1);

    // Hand-computed Q3.2 vectors
    run_op(0, 8, 8, 1'b1, 15, 1'b0);
    run_op(0, -6, 4, 1'b1, -6, 1'b0);
    run_op(0, -16, 4, 1'b1, -16, 1'b0);
    run_op(0, 1, -12, 1'b1, 15, 1'b0);

    // Reset while multiplying aborts the operation
    drive(1, 4, 28, 1'b1);
    tick();
    exp_done[1] = 1'b0;
    drive(1, 0, 0, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    exp_done[0] = 1'b1;
    exp_done[1] = 1'b1;
    exp_res[0]  = 0;
    exp_res[1]  = 0;
    rst = 1'b0;
    tick();
    tick();

    // Exhaustive Q3.2 sweep, back-to-back operations
    for (int av = 0; av < 32; av++) begin
      for (int bv = 0; bv < 32; bv++) begin
        run_op(0, av, bv, 1'b0, 0, 1'b0);
      end
    end
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
